// File: rtl/axi_ddr_vfifo_pkg.sv
// Shared constants and types for the two-channel virtual FIFO.
package axi_ddr_vfifo_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int NUM_CH     = 2;

    typedef enum logic [0:0] {
        INIT_WAIT = 1'b0,
        INIT_DONE = 1'b1
    } init_state_t;

    // A count must hold 0..depth inclusive, hence one bit more than the pointer.
    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/axi_ddr_vfifo_if.sv
// AXI4-Stream write (s) and read (m) buses of the virtual FIFO.
interface axi_ddr_vfifo_if
    import axi_ddr_vfifo_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
);
    logic              ext_s_axis_tvalid;
    logic              ext_s_axis_tready;
    logic              ext_s_axis_tlast;
    logic [DATA_W-1:0] ext_s_axis_tdata;
    logic              ext_s_axis_tdest;
    logic              ext_m_axis_tvalid;
    logic              ext_m_axis_tready;
    logic              ext_m_axis_tlast;
    logic [DATA_W-1:0] ext_m_axis_tdata;
    logic              ext_m_axis_tdest;

    // A beat transfers on a rising edge with tvalid && tready; the source holds
    // tvalid and payload stable until then, and tvalid never waits on tready.
    modport slave (
        input  ext_s_axis_tvalid, ext_s_axis_tlast, ext_s_axis_tdata, ext_s_axis_tdest,
        output ext_s_axis_tready,
        output ext_m_axis_tvalid, ext_m_axis_tlast, ext_m_axis_tdata, ext_m_axis_tdest,
        input  ext_m_axis_tready
    );

    modport master (
        output ext_s_axis_tvalid, ext_s_axis_tlast, ext_s_axis_tdata, ext_s_axis_tdest,
        input  ext_s_axis_tready,
        input  ext_m_axis_tvalid, ext_m_axis_tlast, ext_m_axis_tdata, ext_m_axis_tdest,
        output ext_m_axis_tready
    );

endinterface

// File: rtl/axi_ddr_vfifo_channel.sv
// One circular-buffer channel: storage, pointers, occupancy count and flags.
module vfifo_channel
    import axi_ddr_vfifo_pkg::*;
#(
    parameter int W     = DATA_W_DEF + 1,
    parameter int DEPTH = 4096,
    parameter int BURST = 128
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    input  logic         peek_next,
    output logic [W-1:0] head_data,
    output logic         single,
    output logic         full,
    output logic         almost_full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = cnt_w(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          do_push;
    logic          do_pop;

    // A push while full is refused even when a pop happens in the same cycle.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: ;
            endcase
        end
    end

    // peek_next lets a registered consumer fetch the word behind the one it pops.
    assign head_data   = mem[rd_ptr + AW'(peek_next)];
    assign single      = (count == CW'(1));
    assign full        = (count == CW'(DEPTH));
    assign almost_full = (count >= CW'(DEPTH - BURST));
    assign empty       = (count == '0);

endmodule

// File: rtl/axi_ddr_vfifo.sv
// Two-channel virtual FIFO: stream path on channel 0, generic port on channel 1.
module axi_ddr_vfifo
    import axi_ddr_vfifo_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEF,
    parameter int CH_DEPTH    = 4096,
    parameter int BURST_WORDS = 128,
    parameter int INIT_CYCLES = 64
) (
    input  logic              aclk,
    input  logic              aresetn,
    axi_ddr_vfifo_if.slave    axis,
    input  logic              write,
    input  logic              read,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              full,
    output logic              empty,
    output logic [NUM_CH-1:0] ext_vfifo_s2mm_channel_full,
    output logic [NUM_CH-1:0] ext_vfifo_mm2s_channel_full,
    output logic [NUM_CH-1:0] ext_vfifo_mm2s_channel_empty,
    output logic [NUM_CH-1:0] ext_vfifo_idle,
    output logic              vfifo_s2mm_overrun_err_intr,
    output logic              vfifo_mm2s_rresp_err_intr,
    output logic              vfifo_s2mm_bresp_err_intr,
    output logic              init_calib_complete,
    output init_state_t       init_state
);
    localparam int IW = $clog2(INIT_CYCLES + 1);

    logic [NUM_CH-1:0] ch_full, ch_afull, ch_empty, ch_single;
    logic [DATA_W:0]   head0, head1, push1_data;
    logic [IW-1:0]     init_cnt;
    logic              s_beat, push0, push1, pop0, pop1, gen_wr, nxt_valid;
    logic [1:0]        unused_ch1;

    // Calibration stand-in: ready exactly INIT_CYCLES edges after reset release.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            init_state          <= INIT_WAIT;
            init_cnt            <= '0;
            init_calib_complete <= 1'b0;
        end else begin
            case (init_state)
                INIT_WAIT: begin
                    if (init_cnt == IW'(INIT_CYCLES - 1)) begin
                        init_state          <= INIT_DONE;
                        init_calib_complete <= 1'b1;
                    end else begin
                        init_cnt <= init_cnt + IW'(1);
                    end
                end
                INIT_DONE: init_calib_complete <= 1'b1;
            endcase
        end
    end

    assign full   = ch_full[1] || !init_calib_complete;
    assign empty  = ch_empty[1];
    assign gen_wr = write && !full;

    // Generic write wins channel 1; a tdest=1 beat waits out that cycle.
    assign axis.ext_s_axis_tready = init_calib_complete &&
        (axis.ext_s_axis_tdest ? (!ch_full[1] && !write) : !ch_full[0]);
    assign s_beat     = axis.ext_s_axis_tvalid && axis.ext_s_axis_tready;
    assign push0      = s_beat && !axis.ext_s_axis_tdest;
    assign push1      = gen_wr || (s_beat && axis.ext_s_axis_tdest);
    assign push1_data = gen_wr ? {1'b0, data_in} : {axis.ext_s_axis_tlast, axis.ext_s_axis_tdata};
    assign pop0       = axis.ext_m_axis_tvalid && axis.ext_m_axis_tready;
    assign pop1       = read && !ch_empty[1];

    vfifo_channel #(.W(DATA_W + 1), .DEPTH(CH_DEPTH), .BURST(BURST_WORDS)) u_ch0 (
        .clk(aclk), .rst_n(aresetn), .push(push0),
        .push_data({axis.ext_s_axis_tlast, axis.ext_s_axis_tdata}),
        .pop(pop0), .peek_next(pop0), .head_data(head0), .single(ch_single[0]),
        .full(ch_full[0]), .almost_full(ch_afull[0]), .empty(ch_empty[0])
    );

    vfifo_channel #(.W(DATA_W + 1), .DEPTH(CH_DEPTH), .BURST(BURST_WORDS)) u_ch1 (
        .clk(aclk), .rst_n(aresetn), .push(push1), .push_data(push1_data),
        .pop(pop1), .peek_next(1'b0), .head_data(head1), .single(ch_single[1]),
        .full(ch_full[1]), .almost_full(ch_afull[1]), .empty(ch_empty[1])
    );

    assign unused_ch1 = {head1[DATA_W], ch_single[1]};

    // The output register mirrors the channel head; the word stays counted
    // in the channel until the consumer takes it.
    assign nxt_valid = !ch_empty[0] && !(pop0 && ch_single[0]);

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            axis.ext_m_axis_tvalid      <= 1'b0;
            axis.ext_m_axis_tdata       <= '0;
            axis.ext_m_axis_tlast       <= 1'b0;
            data_out                    <= '0;
            vfifo_s2mm_overrun_err_intr <= 1'b0;
            vfifo_mm2s_rresp_err_intr   <= 1'b0;
        end else begin
            axis.ext_m_axis_tvalid <= nxt_valid;
            if (nxt_valid) begin
                axis.ext_m_axis_tdata <= head0[DATA_W-1:0];
                axis.ext_m_axis_tlast <= head0[DATA_W];
            end
            if (pop1) data_out <= head1[DATA_W-1:0];
            if (write && full)          vfifo_s2mm_overrun_err_intr <= 1'b1;
            if (read && ch_empty[1])    vfifo_mm2s_rresp_err_intr   <= 1'b1;
        end
    end

    assign axis.ext_m_axis_tdest        = 1'b0;
    assign vfifo_s2mm_bresp_err_intr    = 1'b0;
    assign ext_vfifo_s2mm_channel_full  = ch_full | {NUM_CH{!init_calib_complete}};
    assign ext_vfifo_mm2s_channel_full  = ch_afull;
    assign ext_vfifo_mm2s_channel_empty = ch_empty;
    assign ext_vfifo_idle = {ch_empty[1] && !push1 && !pop1, ch_empty[0] && !push0 && !pop0};

endmodule

// File: tb/tb_axi_ddr_vfifo.sv
// Directed bench for axi_ddr_vfifo: init timing, stream fill/drain with wrap and stalls, generic port.
module tb_axi_ddr_vfifo;
  import axi_ddr_vfifo_pkg::*;

  localparam int DW    = 32;
  localparam int DEPTH = 4096;
  localparam int BURST = 128;
  localparam int INITC = 64;

  logic              clk_tb = 1'b0;
  logic              aresetn;
  logic              write, read;
  logic [DW-1:0]     data_in, data_out;
  logic              full, empty;
  logic [1:0]        s2mm_full, mm2s_full, mm2s_empty, vidle;
  logic              overrun_err, rresp_err, bresp_err, init_done;
  init_state_t       init_state;

  int n_checks = 0;
  int n_fail   = 0;
  logic [DW:0] exp_q[$];

  typedef struct {
    logic          w;
    logic          r;
    logic [DW-1:0] d;
    logic [DW-1:0] exp_dout;
    logic          exp_empty;
    logic          exp_rresp;
  } gen_vec_t;
  gen_vec_t vecs[11];

  axi_ddr_vfifo_if #(.DATA_W(DW)) vif ();

  axi_ddr_vfifo #(.DATA_W(DW), .CH_DEPTH(DEPTH), .BURST_WORDS(BURST), .INIT_CYCLES(INITC)) dut (
    .aclk(clk_tb), .aresetn(aresetn), .axis(vif),
    .write(write), .read(read), .data_in(data_in), .data_out(data_out),
    .full(full), .empty(empty),
    .ext_vfifo_s2mm_channel_full(s2mm_full), .ext_vfifo_mm2s_channel_full(mm2s_full),
    .ext_vfifo_mm2s_channel_empty(mm2s_empty), .ext_vfifo_idle(vidle),
    .vfifo_s2mm_overrun_err_intr(overrun_err), .vfifo_mm2s_rresp_err_intr(rresp_err),
    .vfifo_s2mm_bresp_err_intr(bresp_err), .init_calib_complete(init_done),
    .init_state(init_state)
  );

  // clock / watchdog
  always #5 clk_tb = ~clk_tb;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not reach the end, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic idle_inputs();
    vif.ext_s_axis_tvalid = 1'b0;
    vif.ext_s_axis_tlast  = 1'b0;
    vif.ext_s_axis_tdata  = '0;
    vif.ext_s_axis_tdest  = 1'b0;
    vif.ext_m_axis_tready = 1'b0;
    write   = 1'b0;
    read    = 1'b0;
    data_in = '0;
  endtask

  task automatic stream_beat(input logic [DW-1:0] d, input logic last, input logic dest);
    bit ok;
    ok = 1'b0;
    @(negedge clk_tb);
    vif.ext_s_axis_tvalid = 1'b1;
    vif.ext_s_axis_tdata  = d;
    vif.ext_s_axis_tlast  = last;
    vif.ext_s_axis_tdest  = dest;
    for (int t = 0; t < 5000 && !ok; t++) begin
      #1;
      if (vif.ext_s_axis_tready) ok = 1'b1;
      else @(negedge clk_tb);
    end
    if (ok) begin
      @(posedge clk_tb);
      #1;
      if (!dest) exp_q.push_back({last, d});
    end else begin
      check("s_axis accept timeout", ok, 1);
    end
    vif.ext_s_axis_tvalid = 1'b0;
    vif.ext_s_axis_tlast  = 1'b0;
  endtask

  // scoreboard side: consume n beats from ext_m_axis against exp_q
  task automatic drain(input int n, input bit random_stall);
    int got;
    int cyc;
    bit stalled;
    logic [DW:0] held;
    logic [DW:0] exp_w;
    got = 0; cyc = 0; stalled = 1'b0; held = '0;
    while (got < n && cyc < 20 * n + 200) begin
      @(negedge clk_tb);
      cyc++;
      if (stalled) begin
        check("m_axis tvalid held", vif.ext_m_axis_tvalid, 1);
        check("m_axis data held", {vif.ext_m_axis_tlast, vif.ext_m_axis_tdata}, held);
      end
      vif.ext_m_axis_tready = random_stall ? ($urandom_range(0, 3) != 0) : 1'b1;
      held    = {vif.ext_m_axis_tlast, vif.ext_m_axis_tdata};
      stalled = vif.ext_m_axis_tvalid && !vif.ext_m_axis_tready;
      if (vif.ext_m_axis_tvalid && vif.ext_m_axis_tready) begin
        if (exp_q.size() == 0) begin
          check("m_axis beat with empty queue", exp_q.size(), 1);
        end else begin
          exp_w = exp_q.pop_front();
          check("m_axis beat", {vif.ext_m_axis_tlast, vif.ext_m_axis_tdata}, exp_w);
          check("m_axis tdest", vif.ext_m_axis_tdest, 0);
        end
        got++;
      end
    end
    check("drain beat count", got, n);
    @(negedge clk_tb);
    vif.ext_m_axis_tready = 1'b0;
  endtask

  initial begin
    // generic-port vectors: 5 writes, 5 reads, then a read on empty
    vecs[0]  = '{1'b1, 1'b0, 32'hA1, 32'h0,  1'b0, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 32'hA2, 32'h0,  1'b0, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 32'hA3, 32'h0,  1'b0, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 32'hA4, 32'h0,  1'b0, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 32'hA5, 32'h0,  1'b0, 1'b0};
    vecs[5]  = '{1'b0, 1'b1, 32'h0,  32'hA1, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 32'h0,  32'hA2, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 32'h0,  32'hA3, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 1'b1, 32'h0,  32'hA4, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 32'h0,  32'hA5, 1'b1, 1'b0};
    vecs[10] = '{1'b0, 1'b1, 32'h0,  32'hA5, 1'b1, 1'b1};

    // reset state
    aresetn = 1'b0;
    idle_inputs();
    repeat (3) @(negedge clk_tb);
    check("rst init_calib_complete", init_done, 0);
    check("rst init_state", init_state, INIT_WAIT);
    check("rst s_tready", vif.ext_s_axis_tready, 0);
    check("rst m_tvalid", vif.ext_m_axis_tvalid, 0);
    check("rst m_tlast", vif.ext_m_axis_tlast, 0);
    check("rst m_tdata", vif.ext_m_axis_tdata, 0);
    check("rst m_tdest", vif.ext_m_axis_tdest, 0);
    check("rst data_out", data_out, 0);
    check("rst full", full, 1);
    check("rst empty", empty, 1);
    check("rst s2mm_full", s2mm_full, 2'b11);
    check("rst mm2s_full", mm2s_full, 2'b00);
    check("rst mm2s_empty", mm2s_empty, 2'b11);
    check("rst idle", vidle, 2'b11);
    check("rst overrun", overrun_err, 0);
    check("rst rresp", rresp_err, 0);
    check("rst bresp", bresp_err, 0);

    // init timing: counted in rising edges after release
    aresetn = 1'b1;
    for (int k = 1; k <= INITC; k++) begin
      @(posedge clk_tb);
      #1;
      if (k == INITC - 1) begin
        check("init low at edge 63", init_done, 0);
        check("s_tready during init", vif.ext_s_axis_tready, 0);
        check("empty during init", empty, 1);
        check("full during init", full, 1);
      end
      if (k == INITC) begin
        check("init high at edge 64", init_done, 1);
        check("init_state done", init_state, INIT_DONE);
        check("full after init", full, 0);
        check("s2mm_full after init", s2mm_full, 2'b00);
      end
    end

    // generic port table
    @(negedge clk_tb);
    for (int r = 0; r < 11; r++) begin
      write   = vecs[r].w;
      read    = vecs[r].r;
      data_in = vecs[r].d;
      @(negedge clk_tb);
      check($sformatf("gen vec %0d data_out", r), data_out, vecs[r].exp_dout);
      check($sformatf("gen vec %0d empty", r), empty, vecs[r].exp_empty);
      check($sformatf("gen vec %0d rresp", r), rresp_err, vecs[r].exp_rresp);
    end
    write = 1'b0;
    read  = 1'b0;

    // write priority over a tdest=1 beat, then that beat lands behind it
    @(negedge clk_tb);
    vif.ext_s_axis_tvalid = 1'b1;
    vif.ext_s_axis_tdest  = 1'b1;
    vif.ext_s_axis_tdata  = 32'h7777;
    vif.ext_s_axis_tlast  = 1'b1;
    write   = 1'b1;
    data_in = 32'h5555;
    #1;
    check("s_tready write priority", vif.ext_s_axis_tready, 0);
    check("idle ch1 during write", vidle[1], 0);
    @(posedge clk_tb);
    #1;
    write = 1'b0;
    #1;
    check("s_tready ch1 free", vif.ext_s_axis_tready, 1);
    @(posedge clk_tb);
    #1;
    vif.ext_s_axis_tvalid = 1'b0;
    vif.ext_s_axis_tdest  = 1'b0;
    vif.ext_s_axis_tlast  = 1'b0;
    @(negedge clk_tb);
    read = 1'b1;
    @(negedge clk_tb);
    check("ch1 read generic word", data_out, 32'h5555);
    @(negedge clk_tb);
    check("ch1 read stream word", data_out, 32'h7777);
    read = 1'b0;
    check("ch1 empty after reads", empty, 1);
    check("idle both quiet", vidle, 2'b11);

    // channel 1 fill to CH_DEPTH, overrun, drain
    for (int j = 0; j < DEPTH; j++) begin
      @(negedge clk_tb);
      if (j == DEPTH - BURST - 1) check("mm2s_full[1] below margin", mm2s_full[1], 0);
      if (j == DEPTH - BURST)     check("mm2s_full[1] at margin", mm2s_full[1], 1);
      if (j == DEPTH - 1)         check("full one below depth", full, 0);
      write   = 1'b1;
      data_in = 32'h1000_0000 + j;
    end
    @(negedge clk_tb);
    check("full at depth", full, 1);
    check("s2mm_full[1] at depth", s2mm_full[1], 1);
    check("overrun before extra write", overrun_err, 0);
    data_in = 32'hDEAD_BEEF;
    @(negedge clk_tb);
    check("overrun after extra write", overrun_err, 1);
    write = 1'b0;
    read  = 1'b1;
    for (int j = 0; j < DEPTH; j++) begin
      @(negedge clk_tb);
      check("ch1 drain word", data_out, 32'h1000_0000 + j);
    end
    read = 1'b0;
    check("ch1 empty after drain", empty, 1);

    // channel 0 fill with output stalled
    for (int i = 0; i < DEPTH; i++) begin
      stream_beat(i, (i % 16) == 15, 1'b0);
      if (i == 0) check("m_tvalid one edge after accept", vif.ext_m_axis_tvalid, 0);
      if (i == 1) begin
        check("m_tvalid two edges after accept", vif.ext_m_axis_tvalid, 1);
        check("m_tdata first word", vif.ext_m_axis_tdata, 0);
      end
    end
    @(negedge clk_tb);
    vif.ext_s_axis_tvalid = 1'b1;
    vif.ext_s_axis_tdata  = 32'hFFFF;
    #1;
    check("s_tready ch0 full", vif.ext_s_axis_tready, 0);
    check("s2mm_full[0] at depth", s2mm_full[0], 1);
    check("mm2s_full[0] at depth", mm2s_full[0], 1);
    check("m_tdata held while stalled", vif.ext_m_axis_tdata, 0);
    vif.ext_s_axis_tvalid = 1'b0;

    drain(DEPTH, 1'b0);
    check("mm2s_empty[0] after drain", mm2s_empty[0], 1);
    check("m_tvalid after drain", vif.ext_m_axis_tvalid, 0);

    // shift pointers off zero, then a full-depth run across the wrap with stalls
    for (int i = 0; i < 100; i++) stream_beat(32'hA000_0000 + i, 1'b0, 1'b0);
    drain(100, 1'b0);
    fork
      begin
        for (int i = DEPTH; i < 2 * DEPTH; i++) stream_beat(i, (i % 7) == 0, 1'b0);
      end
      begin
        drain(DEPTH, 1'b1);
      end
    join
    check("mm2s_empty[0] after wrap run", mm2s_empty[0], 1);

    // reset mid-operation discards stored words and sticky flags
    for (int i = 0; i < 3; i++) stream_beat(32'hC0 + i, 1'b0, 1'b0);
    @(negedge clk_tb);
    write   = 1'b1;
    data_in = 32'hC1C1;
    @(negedge clk_tb);
    write   = 1'b0;
    aresetn = 1'b0;
    #1;
    exp_q.delete();
    check("midrst m_tvalid", vif.ext_m_axis_tvalid, 0);
    check("midrst mm2s_empty", mm2s_empty, 2'b11);
    check("midrst empty", empty, 1);
    check("midrst overrun", overrun_err, 0);
    check("midrst rresp", rresp_err, 0);
    check("midrst init", init_done, 0);
    @(negedge clk_tb);
    aresetn = 1'b1;
    repeat (INITC + 2) @(negedge clk_tb);
    check("post midrst init", init_done, 1);
    check("post midrst mm2s_empty", mm2s_empty, 2'b11);
    check("post midrst m_tvalid", vif.ext_m_axis_tvalid, 0);

    // final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
